lut_layer_sequencer: RTL

//  Time-multiplexed evaluator for one LogicNets layer of FANIN-input, 1-bit-output truth-table neurons.

---
 rtl/lut_layer_sequencer_if.sv | 34 +++
 rtl/lut_layer_sequencer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/lut_layer_sequencer_if.sv
// Handshake bundle for lut_layer_sequencer: config port, input stream, result stream and status.
interface lut_layer_sequencer_if #(
    parameter int FANIN   = 6,
    parameter int NEURONS = 8,
    parameter int IN_W    = 16
);
    localparam int TBL_W  = 2 ** FANIN;
    // One spare index bit so out-of-range neuron numbers can be presented and flagged.
    localparam int NIDX_W = $clog2(NEURONS) + 1;

    logic              cfg_valid;
    logic              cfg_ready;
    logic              cfg_sel;
    logic [NIDX_W-1:0] cfg_neuron;
    logic [TBL_W-1:0]  cfg_data;
    logic              cfg_err;
    logic              s_valid;
    logic              s_ready;
    logic [IN_W-1:0]   s_data;
    logic              m_valid;
    logic              m_ready;
    logic [NEURONS-1:0] m_data;
    logic              busy;

    modport master (
        output cfg_valid, cfg_sel, cfg_neuron, cfg_data, s_valid, s_data, m_ready,
        input  cfg_ready, cfg_err, s_ready, m_valid, m_data, busy
    );

    modport slave (
        input  cfg_valid, cfg_sel, cfg_neuron, cfg_data, s_valid, s_data, m_ready,
        output cfg_ready, cfg_err, s_ready, m_valid, m_data, busy
    );
endinterface

// File: rtl/lut_layer_sequencer.sv
// Time-multiplexed LogicNets layer: one FANIN-input truth-table neuron evaluated per clock,
// with run-time table/connectivity reconfiguration locked out while a vector is in flight.
module lut_layer_sequencer #(
    parameter int FANIN   = 6,
    parameter int NEURONS = 8,
    parameter int IN_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lut_layer_sequencer_if.slave bus
);
    localparam int TBL_W  = 2 ** FANIN;
    localparam int SEL_W  = $clog2(IN_W);
    localparam int SELS_W = FANIN * SEL_W;
    localparam int CNT_W  = (NEURONS > 1) ? $clog2(NEURONS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IN_W-1:0]    in_q;
    logic [NEURONS-1:0] m_data_q;
    logic               cfg_err_q;
    logic [TBL_W-1:0]   tbl_q [NEURONS];
    logic [SELS_W-1:0]  sel_q [NEURONS];

    logic               cfg_ready_s;
    logic               s_ready_s;
    logic               cfg_fire_s;
    logic               s_fire_s;
    logic               cfg_in_range_s;
    logic [FANIN-1:0]   addr_s;

    // Build the table address: bit k comes from the input picked by select field k; unmapped selects read 0.
    function automatic logic [FANIN-1:0] gather_addr(input logic [SELS_W-1:0] sel,
                                                      input logic [IN_W-1:0]   vec);
        logic [FANIN-1:0] a;
        logic [SEL_W-1:0] idx;
        a = '0;
        for (int k = 0; k < FANIN; k++) begin
            idx = sel[k*SEL_W +: SEL_W];
            if (int'(idx) < IN_W) begin
                a[k] = vec[idx];
            end else begin
                a[k] = 1'b0;
            end
        end
        return a;
    endfunction

    assign addr_s         = gather_addr(sel_q[cnt_q], in_q);
    assign cfg_in_range_s = (int'(bus.cfg_neuron) < NEURONS);
    assign cfg_fire_s     = bus.cfg_valid & cfg_ready_s;
    assign s_fire_s       = bus.s_valid & s_ready_s;

    assign bus.cfg_ready  = cfg_ready_s;
    assign bus.s_ready    = s_ready_s;
    assign bus.m_valid    = (state_q == ST_OUT);
    assign bus.m_data     = m_data_q;
    assign bus.cfg_err    = cfg_err_q;
    assign bus.busy       = (state_q != ST_IDLE);

    // State and neuron counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and handshake readiness; config wins over a same-cycle input vector.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cfg_ready_s = 1'b0;
        s_ready_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cfg_ready_s = 1'b1;
                s_ready_s   = ~bus.cfg_valid;
                if (bus.s_valid && !bus.cfg_valid) begin
                    state_d = ST_EVAL;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EVAL: begin
                if (cnt_q == CNT_W'(NEURONS - 1)) begin
                    state_d = ST_OUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_OUT: begin
                if (bus.m_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Configuration storage, input capture, error pulse and bit-serial result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NEURONS; i++) begin
                tbl_q[i] <= '0;
                sel_q[i] <= '0;
            end
            in_q      <= '0;
            m_data_q  <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_fire_s & ~cfg_in_range_s;
            if (cfg_fire_s && cfg_in_range_s) begin
                if (bus.cfg_sel) begin
                    sel_q[bus.cfg_neuron[CNT_W-1:0]] <= bus.cfg_data[SELS_W-1:0];
                end else begin
                    tbl_q[bus.cfg_neuron[CNT_W-1:0]] <= bus.cfg_data;
                end
            end
            if (s_fire_s) begin
                in_q <= bus.s_data;
            end
            if (state_q == ST_EVAL) begin
                m_data_q[cnt_q] <= tbl_q[cnt_q][addr_s];
            end
        end
    end
endmodule
